// File: rtl/seg_decode_pkg.sv
// Character codes, active-low segment patterns (hgfedcba) and the pattern-to-character decoder.
package seg_decode_pkg;

    typedef enum logic [4:0] {
        CH_0 = 5'd0,  CH_1 = 5'd1,  CH_2 = 5'd2,  CH_3 = 5'd3,
        CH_4 = 5'd4,  CH_5 = 5'd5,  CH_6 = 5'd6,  CH_7 = 5'd7,
        CH_8 = 5'd8,  CH_9 = 5'd9,  CH_A = 5'd10, CH_B = 5'd11,
        CH_C = 5'd12, CH_D = 5'd13, CH_E = 5'd14, CH_F = 5'd15,
        CH_H = 5'd16, CH_I = 5'd17, CH_P = 5'd18, CH_BLANK = 5'd19,
        CH_L = 5'd20, CH_MINUS = 5'd21, CH_UNDER = 5'd22, CH_UNKNOWN = 5'd31
    } char_t;

    localparam logic [7:0] SEG_0     = 8'b11000000;
    localparam logic [7:0] SEG_1     = 8'b11111001;
    localparam logic [7:0] SEG_2     = 8'b10100100;
    localparam logic [7:0] SEG_3     = 8'b10110000;
    localparam logic [7:0] SEG_4     = 8'b10011001;
    localparam logic [7:0] SEG_5     = 8'b10010010;
    localparam logic [7:0] SEG_6     = 8'b10000010;
    localparam logic [7:0] SEG_7     = 8'b11111000;
    localparam logic [7:0] SEG_8     = 8'b10000000;
    localparam logic [7:0] SEG_9     = 8'b10010000;
    localparam logic [7:0] SEG_A     = 8'b10001000;
    localparam logic [7:0] SEG_B     = 8'b10000011;
    localparam logic [7:0] SEG_C     = 8'b11000110;
    localparam logic [7:0] SEG_D     = 8'b10100001;
    localparam logic [7:0] SEG_E     = 8'b10000110;
    localparam logic [7:0] SEG_F     = 8'b10001110;
    localparam logic [7:0] SEG_H     = 8'b10001011;
    localparam logic [7:0] SEG_I     = 8'b11001111;
    localparam logic [7:0] SEG_P     = 8'b10001100;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_L     = 8'b11000111;
    localparam logic [7:0] SEG_MINUS = 8'b10111111;
    localparam logic [7:0] SEG_UNDER = 8'b11110111;

    // lit: gfedcba with 1 = segment lit; the table is kept in active-low form
    function automatic char_t seg_to_char(input logic [6:0] lit);
        logic [6:0] pat;
        char_t      ch;
        pat = ~lit;
        ch  = CH_UNKNOWN;
        case (pat)
            SEG_0[6:0]:     ch = CH_0;
            SEG_1[6:0]:     ch = CH_1;
            SEG_2[6:0]:     ch = CH_2;
            SEG_3[6:0]:     ch = CH_3;
            SEG_4[6:0]:     ch = CH_4;
            SEG_5[6:0]:     ch = CH_5;
            SEG_6[6:0]:     ch = CH_6;
            SEG_7[6:0]:     ch = CH_7;
            SEG_8[6:0]:     ch = CH_8;
            SEG_9[6:0]:     ch = CH_9;
            SEG_A[6:0]:     ch = CH_A;
            SEG_B[6:0]:     ch = CH_B;
            SEG_C[6:0]:     ch = CH_C;
            SEG_D[6:0]:     ch = CH_D;
            SEG_E[6:0]:     ch = CH_E;
            SEG_F[6:0]:     ch = CH_F;
            SEG_H[6:0]:     ch = CH_H;
            SEG_I[6:0]:     ch = CH_I;
            SEG_P[6:0]:     ch = CH_P;
            SEG_BLANK[6:0]: ch = CH_BLANK;
            SEG_L[6:0]:     ch = CH_L;
            SEG_MINUS[6:0]: ch = CH_MINUS;
            SEG_UNDER[6:0]: ch = CH_UNDER;
            default:        ch = CH_UNKNOWN;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Decoded-character output port: valid/ready handshake plus digit index, code and flags.
interface seven_seg_scan_decoder_if
    import seg_decode_pkg::*;
#(
    parameter int unsigned N_DIGITS = 6
);
    localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_digit;
    char_t         out_code;
    logic          out_dp;
    logic          out_unknown;

    modport master (output out_valid, out_digit, out_code, out_dp, out_unknown, input out_ready);
    modport slave  (input out_valid, out_digit, out_code, out_dp, out_unknown, output out_ready);
endinterface

// File: rtl/seg_bus_settle.sv
// Synchronises the raw display bus, normalises polarity and strobes one capture per settled dwell.
module seg_bus_settle #(
    parameter int unsigned N_DIGITS       = 6,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          seg_in,
    input  logic [N_DIGITS-1:0] dig_in,
    output logic [7:0]          seg_c,
    output logic [N_DIGITS-1:0] dig_c,
    output logic                capture_c
);
    localparam int unsigned   BW      = N_DIGITS + 8;
    localparam int unsigned   CW      = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

    logic [BW-1:0] sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          change_c;

    assign change_c  = (sync2_q != prev_q);
    assign capture_c = armed_q && (cnt_q == CNT_MAX);

    // armed survives reset so a bus already stable at release is still captured once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync1_q <= {dig_in, seg_in};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (change_c)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CW'(1);
            if (change_c)
                armed_q <= 1'b1;
            else if (capture_c)
                armed_q <= 1'b0;
        end
    end

    assign seg_c = SEG_ACTIVE_LOW ? ~prev_q[7:0]    : prev_q[7:0];
    assign dig_c = DIG_ACTIVE_LOW ? ~prev_q[BW-1:8] : prev_q[BW-1:8];

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Reads a multiplexed 7-segment bus back into character codes on a one-entry valid/ready buffer.
// Optional SEVEN_SEG_DECODER_CHANGE_ONLY_EN: emit a digit only when it differs from its last capture.
module seven_seg_scan_decoder
    import seg_decode_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 6,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               seg_in,
    input  logic [N_DIGITS-1:0]      dig_in,
    seven_seg_scan_decoder_if.master dout,
    output logic                     multi_sel,
    output logic                     overrun
);
    localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned NW = $clog2(N_DIGITS + 1);

    logic [7:0]          seg_c;
    logic [N_DIGITS-1:0] dig_c;
    logic                capture_c;
    logic [NW-1:0]       n_en_c;
    logic [DW-1:0]       idx_c;
    char_t               code_c;
    logic                qual_c, emit_c;

    logic          valid_q, valid_d, dp_q, dp_d, unk_q, unk_d;
    logic          multi_q, multi_d, ovr_q, ovr_d;
    logic [DW-1:0] digit_q, digit_d;
    char_t         code_q, code_d;

    seg_bus_settle #(
        .N_DIGITS       (N_DIGITS),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW (DIG_ACTIVE_LOW)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_in    (dig_in),
        .seg_c     (seg_c),
        .dig_c     (dig_c),
        .capture_c (capture_c)
    );

    // count enabled digits and remember the index of the (last) one
    always_comb begin
        n_en_c = '0;
        idx_c  = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (dig_c[i]) begin
                n_en_c = n_en_c + NW'(1);
                idx_c  = DW'(i);
            end
        end
    end

    assign code_c = seg_to_char(seg_c[6:0]);
    assign qual_c = capture_c && (n_en_c == NW'(1));

`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
    logic [N_DIGITS-1:0] sh_valid_q, sh_dp_q;
    char_t               sh_code_q [N_DIGITS];

    // shadow follows every qualified capture, even one the full buffer drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid_q <= '0;
            sh_dp_q    <= '0;
            for (int unsigned i = 0; i < N_DIGITS; i++)
                sh_code_q[i] <= CH_0;
        end else if (qual_c) begin
            sh_valid_q[idx_c] <= 1'b1;
            sh_dp_q[idx_c]    <= seg_c[7];
            sh_code_q[idx_c]  <= code_c;
        end
    end

    assign emit_c = qual_c && (!sh_valid_q[idx_c] || (sh_dp_q[idx_c] != seg_c[7]) ||
                               (sh_code_q[idx_c] != code_c));
`else
    assign emit_c = qual_c;
`endif

    // one-entry buffer: accept frees it, a capture on the accept cycle refills it
    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        code_d  = code_q;
        dp_d    = dp_q;
        unk_d   = unk_q;
        multi_d = capture_c && (n_en_c > NW'(1));
        ovr_d   = 1'b0;
        if (valid_q && dout.out_ready)
            valid_d = 1'b0;
        if (emit_c) begin
            if (!valid_q || dout.out_ready) begin
                valid_d = 1'b1;
                digit_d = idx_c;
                code_d  = code_c;
                dp_d    = seg_c[7];
                unk_d   = (code_c == CH_UNKNOWN);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            digit_q <= '0;
            code_q  <= CH_0;
            dp_q    <= 1'b0;
            unk_q   <= 1'b0;
            multi_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            digit_q <= digit_d;
            code_q  <= code_d;
            dp_q    <= dp_d;
            unk_q   <= unk_d;
            multi_q <= multi_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout.out_valid   = valid_q;
    assign dout.out_digit   = digit_q;
    assign dout.out_code    = code_q;
    assign dout.out_dp      = dp_q;
    assign dout.out_unknown = unk_q;
    assign multi_sel        = multi_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: latency, scan decode, back-pressure, multi-select, reset.
module tb_seven_seg_scan_decoder;
    import seg_decode_pkg::*;

    localparam int unsigned N_DIGITS = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [5:0] dig_in;
    logic       multi_sel, overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_multi = 0;
    int n_ovr = 0;

    typedef struct {
        int digit;
        int code;
        int dp;
        int unk;
        int cyc;
    } beat_t;
    beat_t beat_q[$];

    seven_seg_scan_decoder_if #(.N_DIGITS(N_DIGITS)) dif ();

    seven_seg_scan_decoder #(
        .N_DIGITS       (N_DIGITS),
        .SETTLE_CYCLES  (16),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_in    (dig_in),
        .dout      (dif),
        .multi_sel (multi_sel),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record accepted beats and pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (dif.out_valid && dif.out_ready)
            beat_q.push_back('{int'(dif.out_digit), int'(dif.out_code), int'(dif.out_dp),
                               int'(dif.out_unknown), cyc});
        if (multi_sel) n_multi = n_multi + 1;
        if (overrun)   n_ovr = n_ovr + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic beat_t beat_at(input int k);
        beat_t b = '{-1, -1, -1, -1, -1};
        if (k >= 0 && k < beat_q.size()) b = beat_q[k];
        return b;
    endfunction

    task automatic drive(input logic [5:0] d, input logic [7:0] s);
        @(posedge clk);
        #1;
        dig_in = d;
        seg_in = s;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    logic [5:0] t2_dig [6] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
    logic [7:0] t2_seg [6] = '{8'hC6, 8'h8B, 8'h4F, 8'h8C, 8'hFF, 8'hFF};
    int         t2_code [6] = '{12, 16, 17, 18, 19, 19};
    int         t2_dp   [6] = '{0, 0, 1, 0, 0, 0};
    logic [7:0] t6_seg  [6] = '{8'h88, 8'h83, 8'hC7, 8'hBF, 8'hF7, 8'h86};
    int         t6_code [6] = '{10, 11, 20, 21, 22, 14};

    initial begin
        int    b0, c0, m0, o0, exp_beats;
        beat_t b;

        rst_n = 1'b0;
        dig_in = 6'b111111;
        seg_in = 8'hFF;
        dif.out_ready = 1'b1;
        idle(3);
        check("rst_valid", int'(dif.out_valid), 0);
        check("rst_digit", int'(dif.out_digit), 0);
        check("rst_code", int'(dif.out_code), 0);
        check("rst_dp", int'(dif.out_dp), 0);
        check("rst_unknown", int'(dif.out_unknown), 0);
        check("rst_multi", int'(multi_sel), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // no digit enabled: settles but produces nothing
        idle(30);
        check("idle_beats", beat_q.size(), 0);
        check("idle_multi", n_multi, 0);

        // single 'C' on digit 0: one beat 19 cycles after the pin change
        b0 = beat_q.size();
        drive(6'b111110, 8'hC6);
        c0 = cyc;
        idle(40);
        b = beat_at(b0);
        check("t1_beats", beat_q.size() - b0, 1);
        check("t1_latency", b.cyc - c0, 19);
        check("t1_digit", b.digit, 0);
        check("t1_code", b.code, 12);
        check("t1_dp", b.dp, 0);
        check("t1_unknown", b.unk, 0);
        check("t1_valid_after", int'(dif.out_valid), 0);

        // scan "ChI.P" on digits 5..2 with blanks on 1,0
        b0 = beat_q.size();
        for (int k = 0; k < 6; k++) begin
            drive(t2_dig[k], t2_seg[k]);
            idle(62);
        end
        check("t2_beats", beat_q.size() - b0, 6);
        for (int k = 0; k < 6; k++) begin
            b = beat_at(b0 + k);
            check($sformatf("t2_digit%0d", k), b.digit, 5 - k);
            check($sformatf("t2_code%0d", k), b.code, t2_code[k]);
            check($sformatf("t2_dp%0d", k), b.dp, t2_dp[k]);
        end

        // back-pressure: first capture held, next two dropped with overrun
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        b0 = beat_q.size();
        o0 = n_ovr;
        drive(6'b011111, 8'hF9);
        idle(38);
        check("t3_first_valid", int'(dif.out_valid), 1);
        check("t3_first_code", int'(dif.out_code), 1);
        drive(6'b101111, 8'hA4);
        idle(38);
        drive(6'b110111, 8'hB0);
        idle(38);
        check("t3_overruns", n_ovr - o0, 2);
        check("t3_hold_valid", int'(dif.out_valid), 1);
        check("t3_hold_digit", int'(dif.out_digit), 5);
        check("t3_hold_code", int'(dif.out_code), 1);
        check("t3_hold_dp", int'(dif.out_dp), 0);
        check("t3_no_beats", beat_q.size() - b0, 0);
        @(posedge clk);
        #1 dif.out_ready = 1'b1;
        idle(4);
        b = beat_at(b0);
        check("t3_drain_beats", beat_q.size() - b0, 1);
        check("t3_drain_digit", b.digit, 5);
        check("t3_drain_code", b.code, 1);
        check("t3_drain_valid", int'(dif.out_valid), 0);

        // two digits enabled: multi_sel pulse, nothing emitted
        b0 = beat_q.size();
        m0 = n_multi;
        drive(6'b111100, 8'hC0);
        idle(40);
        check("t4_multi", n_multi - m0, 1);
        check("t4_multi_beats", beat_q.size() - b0, 0);
        check("t4_multi_valid", int'(dif.out_valid), 0);

        // unknown pattern on digit 2
        drive(6'b111011, 8'hAA);
        idle(40);
        b = beat_at(b0);
        check("t4_unk_beats", beat_q.size() - b0, 1);
        check("t4_unk_digit", b.digit, 2);
        check("t4_unk_code", b.code, 31);
        check("t4_unk_flag", b.unk, 1);
        check("t4_unk_dp", b.dp, 0);

        // bus toggling faster than the settle window produces nothing
        b0 = beat_q.size();
        for (int i = 0; i < 8; i++) begin
            drive(6'b111101, (i % 2 == 1) ? 8'h92 : 8'h99);
            idle(8);
        end
        check("t5_toggle_beats", beat_q.size() - b0, 0);
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        idle(15);
        check("t5_pending_valid", int'(dif.out_valid), 1);
        check("t5_pending_code", int'(dif.out_code), 5);

        // reset mid-dwell clears outputs, stable bus re-captured after release
        drive(6'b111101, 8'h99);
        idle(8);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", int'(dif.out_valid), 0);
        check("t5_rst_code", int'(dif.out_code), 0);
        check("t5_rst_digit", int'(dif.out_digit), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
        b0 = beat_q.size();
        c0 = cyc;
        idle(30);
        b = beat_at(b0);
        check("t5_rel_beats", beat_q.size() - b0, 1);
        check("t5_rel_latency", b.cyc - c0, 19);
        check("t5_rel_digit", b.digit, 1);
        check("t5_rel_code", b.code, 4);

        // the same 6-digit frame three times
        b0 = beat_q.size();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 6; k++) begin
                drive(t2_dig[k], t6_seg[k]);
                idle(22);
            end
        end
        idle(5);
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
        exp_beats = 6;
`else
        exp_beats = 18;
`endif
        check("t6_beats", beat_q.size() - b0, exp_beats);
        for (int k = 0; k < 6; k++) begin
            b = beat_at(b0 + k);
            check($sformatf("t6_digit%0d", k), b.digit, 5 - k);
            check($sformatf("t6_code%0d", k), b.code, t6_code[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
